// File: rtl/stile_sram_arbiter_pkg.sv
// Shared types for the DiMArch stile SRAM arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package dimarch_arb_pkg;

    // Direction of one accepted SRAM word.
    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } sram_op_t;

    // Arbiter grant state: nobody owns the tile, or one requester holds a burst.
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Width of each per-requester wait-cycle counter.
    localparam int STAT_WIDTH = 16;

endpackage

// File: rtl/stile_sram_arbiter_if.sv
// Requester, tile and response bundle around one stile SRAM arbiter.
// Latency: none (wiring only).
// Backpressure: req_ready per requester; tile and responses have none.
interface stile_sram_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 7
);
    localparam int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          sram_r;
    logic                          sram_w;
    logic [ADDR_WIDTH-1:0]         sram_addr;
    logic [DATA_WIDTH-1:0]         sram_wdata;
    logic [DATA_WIDTH-1:0]         sram_rdata;
    logic                          rsp_valid;
    logic [ID_WIDTH-1:0]           rsp_id;
    logic [DATA_WIDTH-1:0]         rsp_data;

    // Clients plus the tile itself: everything outside the arbiter.
    modport master (
        output req_valid, req_we, req_last, req_addr, req_wdata, sram_rdata,
        input  req_ready, sram_r, sram_w, sram_addr, sram_wdata,
        input  rsp_valid, rsp_id, rsp_data
    );

    // The arbiter.
    modport slave (
        input  req_valid, req_we, req_last, req_addr, req_wdata, sram_rdata,
        output req_ready, sram_r, sram_w, sram_addr, sram_wdata,
        output rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/stile_sram_arbiter_rr_pick.sv
// Round-robin selector: first requester after last_owner, wrapping modulo NUM_REQ.
// Latency: combinational.
// Backpressure: none; all-zero grant when no request is present.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_owner,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx
);
    logic [ID_W-1:0] cand;

    // Scan from farthest to nearest so the nearest requester after last_owner wins.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        cand = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = ID_W'((int'(last_owner) + k) % NUM_REQ);
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end
endmodule

// File: rtl/stile_sram_arbiter.sv
// Round-robin arbiter sharing one single-port DiMArch SRAM tile; optional SRAM_ARB_STATS_EN wait counters.
// Latency: grant and strobe same cycle from IDLE; read response 1 cycle after the read strobe.
// Backpressure: one-hot req_ready to the current winner/owner; responses cannot be stalled.
module stile_sram_arbiter
    import dimarch_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 7,
    parameter int MAX_BURST  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    stile_sram_arbiter_if.slave             bus
`ifdef SRAM_ARB_STATS_EN
    ,
    input  logic                            stat_clr,
    output logic [NUM_REQ*STAT_WIDTH-1:0]   stat_wait
`endif
);
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BEAT_W = $clog2(MAX_BURST + 1);
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BURST);

    arb_state_e          state_q, state_d;
    logic [ID_W-1:0]     owner_q, owner_d;
    logic [ID_W-1:0]     last_owner_q, last_owner_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;

    logic [NUM_REQ-1:0]  pick_gnt;
    logic [ID_W-1:0]     pick_idx;
    logic [NUM_REQ-1:0]  ready;
    logic [ID_W-1:0]     sel;
    logic                accept;
    sram_op_t            op;
    logic                last_sel;

    rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .req        (bus.req_valid),
        .last_owner (last_owner_q),
        .gnt        (pick_gnt),
        .idx        (pick_idx)
    );

    // Grant: round-robin winner in IDLE, the owner alone during a burst; nothing while in reset.
    always_comb begin
        ready  = '0;
        sel    = owner_q;
        accept = 1'b0;
        if (!rst) begin
            if (state_q == IDLE) begin
                ready  = pick_gnt;
                sel    = pick_idx;
                accept = |pick_gnt;
            end else begin
                ready[owner_q] = bus.req_valid[owner_q];
                accept         = bus.req_valid[owner_q];
            end
        end
    end

    assign op       = sram_op_t'(bus.req_we[sel]);
    assign last_sel = bus.req_last[sel];

    assign bus.req_ready  = ready;
    assign bus.sram_r     = accept && (op == READ);
    assign bus.sram_w     = accept && (op == WRITE);
    assign bus.sram_addr  = accept ? bus.req_addr[sel*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign bus.sram_wdata = accept ? bus.req_wdata[sel*DATA_WIDTH +: DATA_WIDTH] : '0;

    // The tile itself holds read data for the cycle after the strobe; the id/valid stage
    // lines up with it and zeroes the data lane whenever no response is due.
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_valid_q ? bus.sram_rdata : '0;

    // Next state: burst ownership, beat count and round-robin pointer; read response tagging.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        beat_d       = beat_q;
        last_owner_d = last_owner_q;
        rsp_valid_d  = accept && (op == READ);
        rsp_id_d     = (accept && (op == READ)) ? sel : rsp_id_q;
        if (accept) begin
            if (state_q == IDLE) begin
                if (last_sel || (MAX_BURST == 1)) begin
                    last_owner_d = sel;
                end else begin
                    state_d = BURST;
                    owner_d = sel;
                    beat_d  = BEAT_W'(1);
                end
            end else begin
                beat_d = beat_q + BEAT_W'(1);
                // A capped burst releases the tile; the owner simply re-competes later.
                if (last_sel || (beat_q + BEAT_W'(1) == BEAT_MAX)) begin
                    state_d      = IDLE;
                    last_owner_d = owner_q;
                end
            end
        end
    end

    // FSM and response register; reset drops any burst and any pending response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            beat_q       <= '0;
            last_owner_q <= ID_W'(NUM_REQ - 1);
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            beat_q       <= beat_d;
            last_owner_q <= last_owner_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

`ifdef SRAM_ARB_STATS_EN
    logic [NUM_REQ-1:0][STAT_WIDTH-1:0] wait_q, wait_d;

    // Count cycles each requester is kept waiting; saturate, and let clear win.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            wait_d[i] = wait_q[i];
            if (stat_clr) begin
                wait_d[i] = '0;
            end else if (bus.req_valid[i] && !ready[i] && (wait_q[i] != '1)) begin
                wait_d[i] = wait_q[i] + 1'b1;
            end
        end
    end

    // Wait counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

    assign stat_wait = wait_q;
`endif

endmodule
